// File: rtl/pattern_detector_pkg.sv
// Shared defaults and width helper for the programmable serial pattern detector.
package pattern_detector_pkg;

  localparam int unsigned DEF_MAX_LEN = 16;
  localparam logic [15:0] DEF_PATTERN = 16'b10010;
  localparam int unsigned DEF_LENGTH  = 5;
  localparam logic        DEF_OVERLAP = 1'b1;

  // Width needed to hold a length in the range 0..max_len inclusive.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/pd_shift_window.sv
// History shift register and saturating fill counter for the pattern detector.
module pd_shift_window
  import pattern_detector_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned LW      = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift,
  input  logic               restart,
  input  logic               clear,
  input  logic               data_in,
  output logic [MAX_LEN-1:0] cand,
  output logic [LW-1:0]      fill
);

  logic [MAX_LEN-1:0] hist;

  assign cand = {hist[MAX_LEN-2:0], data_in};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= cand;
      if (restart) begin
        fill <= '0;
      end else if (fill != LW'(MAX_LEN)) begin
        fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pattern_detector.sv
// Runtime-programmable serial pattern detector with saturating match counter.
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int unsigned        MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned        CNT_W   = 16,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(DEF_PATTERN),
  parameter int unsigned        DEF_LEN = DEF_LENGTH,
  parameter logic               DEF_OVL = DEF_OVERLAP
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      data_valid,
  input  logic                      data_in,
  input  logic                      cfg_we,
  input  logic [MAX_LEN-1:0]        cfg_pattern,
  input  logic [len_w(MAX_LEN)-1:0] cfg_len,
  input  logic                      cfg_overlap,
  input  logic                      clr_cnt,
  output logic                      match,
  output logic [CNT_W-1:0]          match_cnt,
  output logic                      cfg_err,
  output logic                      armed
);

  localparam int unsigned LW = len_w(MAX_LEN);

  logic [MAX_LEN-1:0] pat;
  logic [LW-1:0]      len;
  logic               ovl;
  logic [MAX_LEN-1:0] cand;
  logic [LW-1:0]      fill;
  logic [MAX_LEN-1:0] mask;
  logic               cfg_ok;
  logic               cfg_load;
  logic               shift;
  logic               pat_eq;
  logic               enough;
  logic               hit;

  assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
  assign cfg_load = cfg_we && cfg_ok;
  // A valid bit arriving with an accepted config write is discarded.
  assign shift    = data_valid && !cfg_load;

  // NOTE: default first so no path through the block leaves mask unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign pat_eq = ((cand ^ pat) & mask) == '0;
  assign enough = ((LW+1)'(fill) + (LW+1)'(1)) >= (LW+1)'(len);
  assign hit    = shift && pat_eq && enough;
  assign armed  = (fill >= len);

  pd_shift_window #(
    .MAX_LEN (MAX_LEN),
    .LW      (LW)
  ) u_window (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift   (shift),
    .restart (hit && !ovl),
    .clear   (cfg_load),
    .data_in (data_in),
    .cand    (cand),
    .fill    (fill)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat       <= DEF_PAT;
      len       <= LW'(DEF_LEN);
      ovl       <= DEF_OVL;
      match     <= 1'b0;
      cfg_err   <= 1'b0;
      match_cnt <= '0;
    end else begin
      match   <= hit;
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_load) begin
        pat <= cfg_pattern;
        len <= cfg_len;
        ovl <= cfg_overlap;
      end
      // Clearing still counts a hit landing in the same cycle.
      if (clr_cnt) begin
        match_cnt <= hit ? CNT_W'(1) : '0;
      end else if (hit && (match_cnt != '1)) begin
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector: default and wide-counter instance plus a 2-bit-counter instance.
module tb_pattern_detector;

  logic        clk;
  logic        rst_n;
  logic        data_valid;
  logic        data_in;
  logic        cfg_we;
  logic [15:0] cfg_pattern;
  logic [4:0]  cfg_len;
  logic        cfg_overlap;
  logic        clr_cnt;
  logic        match;
  logic [15:0] match_cnt;
  logic        cfg_err;
  logic        armed;
  logic        match2;
  logic [1:0]  match_cnt2;
  logic        cfg_err2;
  logic        armed2;

  int vecs = 0;
  int errs = 0;

  pattern_detector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .clr_cnt     (clr_cnt),
    .match       (match),
    .match_cnt   (match_cnt),
    .cfg_err     (cfg_err),
    .armed       (armed)
  );

  pattern_detector #(.CNT_W(2)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .clr_cnt     (clr_cnt),
    .match       (match2),
    .match_cnt   (match_cnt2),
    .cfg_err     (cfg_err2),
    .armed       (armed2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_stream(input logic [15:0] bits, input int n,
                            output logic [15:0] m_obs, output logic [15:0] a_obs);
    m_obs = '0;
    a_obs = '0;
    for (int i = 0; i < n; i++) begin
      data_valid = 1'b1;
      data_in    = bits[n-1-i];
      tick();
      m_obs[n-1-i] = match;
      a_obs[n-1-i] = armed;
    end
    data_valid = 1'b0;
    data_in    = 1'b0;
  endtask

  task automatic write_cfg(input logic [15:0] p, input logic [4:0] l, input logic o);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    vecs++;
    if ({match, cfg_err, armed, match_cnt} !== {3'b000, 16'd0}) begin
      errs++;
      $display("FAIL reset_state: match/err/armed/cnt=%b%b%b/%0d required 000/0",
               match, cfg_err, armed, match_cnt);
    end
  endtask

  task automatic test_default_overlap;
    logic [15:0] m, a;
    run_stream(16'b10010010, 8, m, a);
    vecs++;
    if (m[7:0] !== 8'b00001001) begin
      errs++;
      $display("FAIL default_overlap_match: got %b required 00001001", m[7:0]);
    end
    vecs++;
    if (match_cnt !== 16'd2) begin
      errs++;
      $display("FAIL default_overlap_cnt: got %0d required 2", match_cnt);
    end
  endtask

  task automatic test_non_overlap;
    logic [15:0] m, a;
    write_cfg(16'b10010, 5'd5, 1'b0);
    vecs++;
    if ({match, cfg_err} !== 2'b00) begin
      errs++;
      $display("FAIL cfg_load_flags: match/err=%b%b required 00", match, cfg_err);
    end
    run_stream(16'b10010010, 8, m, a);
    vecs++;
    if (m[7:0] !== 8'b00001000) begin
      errs++;
      $display("FAIL non_overlap_match: got %b required 00001000", m[7:0]);
    end
    vecs++;
    if (match_cnt !== 16'd3) begin
      errs++;
      $display("FAIL non_overlap_cnt: got %0d required 3", match_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] m, a;
    write_cfg(16'b111, 5'd3, 1'b1);
    run_stream(16'b11111, 5, m, a);
    vecs++;
    if (m[4:0] !== 5'b00111) begin
      errs++;
      $display("FAIL ones_match: got %b required 00111", m[4:0]);
    end
    vecs++;
    if (a[4:0] !== 5'b00111) begin
      errs++;
      $display("FAIL ones_armed: got %b required 00111", a[4:0]);
    end
    vecs++;
    if (match_cnt !== 16'd6) begin
      errs++;
      $display("FAIL ones_cnt: got %0d required 6", match_cnt);
    end
  endtask

  task automatic test_idle_gap;
    logic [15:0] m, a;
    do_reset();
    run_stream(16'b10, 2, m, a);
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (match !== 1'b0) begin
        errs++;
        $display("FAIL idle_gap_%0d: match=%b required 0", i, match);
      end
    end
    run_stream(16'b010, 3, m, a);
    vecs++;
    if (m[2:0] !== 3'b001) begin
      errs++;
      $display("FAIL idle_resume_match: got %b required 001", m[2:0]);
    end
    tick();
    vecs++;
    if (match !== 1'b0) begin
      errs++;
      $display("FAIL pulse_width: match=%b required 0", match);
    end
    run_stream(16'b1001, 4, m, a);
    vecs++;
    if (m[3:0] !== 4'b0000) begin
      errs++;
      $display("FAIL prefix_no_match: got %b required 0000", m[3:0]);
    end
    data_valid = 1'b1;
    data_in    = 1'b0;
    write_cfg(16'b10010, 5'd5, 1'b1);
    data_valid = 1'b0;
    vecs++;
    if ({match, armed} !== 2'b00) begin
      errs++;
      $display("FAIL cfg_discards_bit: match/armed=%b%b required 00", match, armed);
    end
  endtask

  task automatic test_cfg_err;
    logic [15:0] m, a;
    write_cfg(16'b1, 5'd0, 1'b0);
    vecs++;
    if (cfg_err !== 1'b1) begin
      errs++;
      $display("FAIL len0_err: got %b required 1", cfg_err);
    end
    tick();
    vecs++;
    if (cfg_err !== 1'b0) begin
      errs++;
      $display("FAIL len0_err_pulse: got %b required 0", cfg_err);
    end
    run_stream(16'b10010, 5, m, a);
    vecs++;
    if (m[4:0] !== 5'b00001) begin
      errs++;
      $display("FAIL len0_detect: got %b required 00001", m[4:0]);
    end
    // Oversized write lands together with the first stream bit.
    cfg_we      = 1'b1;
    cfg_pattern = 16'hFFFF;
    cfg_len     = 5'd17;
    cfg_overlap = 1'b0;
    data_valid  = 1'b1;
    data_in     = 1'b1;
    tick();
    cfg_we = 1'b0;
    vecs++;
    if (cfg_err !== 1'b1) begin
      errs++;
      $display("FAIL len17_err: got %b required 1", cfg_err);
    end
    run_stream(16'b0010, 4, m, a);
    vecs++;
    if ({cfg_err, m[3:0]} !== 5'b00001) begin
      errs++;
      $display("FAIL len17_detect: err/match=%b/%b required 0/0001", cfg_err, m[3:0]);
    end
    vecs++;
    if (match_cnt !== 16'd3) begin
      errs++;
      $display("FAIL cfg_err_cnt: got %0d required 3", match_cnt);
    end
  endtask

  task automatic test_saturate_clear;
    logic [15:0] m, a;
    do_reset();
    write_cfg(16'b11, 5'd2, 1'b1);
    run_stream(16'b111111, 6, m, a);
    vecs++;
    if (m[5:0] !== 6'b011111) begin
      errs++;
      $display("FAIL pair_match: got %b required 011111", m[5:0]);
    end
    vecs++;
    if ({match_cnt2, match_cnt} !== {2'd3, 16'd5}) begin
      errs++;
      $display("FAIL saturate: cnt2/cnt=%0d/%0d required 3/5", match_cnt2, match_cnt);
    end
    clr_cnt = 1'b1;
    run_stream(16'b1, 1, m, a);
    clr_cnt = 1'b0;
    vecs++;
    if ({m[0], match_cnt2, match_cnt} !== {1'b1, 2'd1, 16'd1}) begin
      errs++;
      $display("FAIL clr_with_hit: match/cnt2/cnt=%b/%0d/%0d required 1/1/1",
               m[0], match_cnt2, match_cnt);
    end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    vecs++;
    if ({match_cnt2, match_cnt} !== {2'd0, 16'd0}) begin
      errs++;
      $display("FAIL clr_idle: cnt2/cnt=%0d/%0d required 0/0", match_cnt2, match_cnt);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] m, a;
    do_reset();
    run_stream(16'b100, 3, m, a);
    do_reset();
    run_stream(16'b10, 2, m, a);
    vecs++;
    if ({m[1:0], match_cnt} !== {2'b00, 16'd0}) begin
      errs++;
      $display("FAIL reset_mid: match/cnt=%b/%0d required 00/0", m[1:0], match_cnt);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    data_valid  = 1'b0;
    data_in     = 1'b0;
    cfg_we      = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    clr_cnt     = 1'b0;
    @(negedge clk);
    test_reset();
    test_default_overlap();
    test_non_overlap();
    test_back_to_back();
    test_idle_gap();
    test_cfg_err();
    test_saturate_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
